btn_event_scheduler: RTL
========================

// Module: btn_event_scheduler
// PURPOSE
//  Turns N raw (already-synchronised) button levels into a single ordered stream of button-press events.
//  Each press is detected on its rising edge and held as pending per button.
//  A round-robin arbiter moves one pending press per cycle into a small FIFO.
//  Sits between the board buttons and the FSM/display logic, which consumes events with a valid/ready handshake.
// PARAMETERS
//  N_BTN   4  number of button inputs (2..16)
//  DEPTH   4  event FIFO depth, power of two (2..16)
//  CNT_W   8  width of saturating drop counter
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              asynchronous active-low reset
//  btn        in   N_BTN          button levels, synchronous to clk
//  evt_ready  in   1              consumer accepts evt_id this cycle
//  clear_ovf  in   1              clears overflow and drop_cnt
//  evt_valid  out  1              FIFO head holds an event
//  evt_id     out  $clog2(N_BTN)  button index of head event
//  fifo_cnt   out  $clog2(DEPTH)+1  occupied FIFO entries
//  pending    out  N_BTN          per-button press waiting for arbitration
//  overflow   out  1              sticky: at least one press was merged/lost
//  drop_cnt   out  CNT_W          saturating count of merged presses
// BEHAVIOUR
//  Reset (rst=0, async): btn_q, pending, rr_ptr, FIFO ptrs/count, overflow, drop_cnt all 0.
//   So evt_valid=0 and evt_id=0.
//  Reset mid-operation discards all queued and pending events.
//  A button held high across reset release yields exactly one event.
//  Edge detect:
//   - rise[i] = btn[i] & ~btn_q[i], where btn_q is btn registered every cycle.
//   - Held button -> one rise only.
//  Pending:
//   - pending[i] is set on edge E when rise[i]=1 at E.
//   - It is cleared on the edge at which i is granted.
//   - rise[i] and grant[i] in the same cycle: pending[i] stays 1 (new press queued).
//   - rise[i] while pending[i]=1 and not granted: press merged; drop_cnt+1 (saturates at all-ones); overflow<=1.
//  Arbiter:
//   - can_push = (fifo_cnt<DEPTH) | (evt_valid & evt_ready).
//   - If any pending and can_push: grant the first pending index searching from rr_ptr upward, wrapping mod N_BTN.
//   - On grant: rr_ptr <= grant+1 (wraps to 0). At most one grant per cycle.
//   - No grant -> rr_ptr unchanged.
//  FIFO:
//   - push = grant; pop = evt_valid & evt_ready.
//   - Push and pop together: count unchanged, allowed even when full.
//   - Pop when empty is ignored.
//   - Pointers wrap mod DEPTH.
//   - evt_valid = (fifo_cnt!=0); evt_id = head entry.
//   - evt_id stays stable while evt_valid & ~evt_ready.
//   - FIFO full -> presses accumulate in pending. Only a second press on an already-pending button is lost.
//  Latency (empty FIFO, no contention):
//   - btn first sampled high at edge E0 -> pending set at E0.
//   - Pushed at E1 -> evt_valid=1 after E1.
//   - Consumer with evt_ready=1 pops at E2.
//  clear_ovf=1 at edge: overflow<=0, drop_cnt<=0. Takes priority over a same-cycle increment.
// STRUCTURE
//  Package btn_sched_pkg holds:
//   - IDX_W = $clog2(N_BTN), PTR_W = $clog2(DEPTH) as localparam functions;
//   - typedef btn_idx_t.
//  Sub-module btn_rr_arbiter (N_BTN): combinational grant and grant_idx from req/rr_ptr, plus registered rr_ptr.
//  FIFO stays inline: register array plus rd/wr pointers and count.
// TESTING
//  1 Reset with btn=4'b0000, release, pulse btn[2] high 3 cycles -> exactly one event:
//     evt_valid after 2nd sampled edge, evt_id=2.
//  2 btn[0],btn[1],btn[3] rise same cycle, rr_ptr=0, evt_ready=1 ->
//     evt_id sequence 0,1,3 on consecutive cycles; rr_ptr ends at 0.
//  3 evt_ready=0, DEPTH=4, presses on btn 0..3 then press btn1 again ->
//     fifo_cnt=4, pending=4'b0000 then 4'b0010.
//     Then release, press btn1 again -> drop_cnt=1, overflow=1.
//  4 FIFO full, pending[2]=1, evt_ready=1 one cycle ->
//     same-cycle pop+push, fifo_cnt stays 4, evt_id advances, pending[2] clears.
//  5 Assert rst low mid-stream with fifo_cnt=3 ->
//     evt_valid=0, fifo_cnt=0, pending=0 immediately (async). No stale event after release.
//  6 Hold btn[1] through reset release -> one event id 1.
//     Then 300 merged presses -> drop_cnt saturates at 255.
//     Then clear_ovf -> drop_cnt=0, overflow=0.

Source files
------------

// File: rtl/btn_sched_pkg.sv
// Shared sizing helpers and types for the button event scheduler.
package btn_sched_pkg;

  // Index width for a given button count (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO pointer width for a given power-of-two depth (at least one bit).
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int N_BTN_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int IDX_W     = idx_w(N_BTN_DEF);
  localparam int PTR_W     = ptr_w(DEPTH_DEF);

  typedef logic [IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/btn_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index at or above rr_ptr
// (wrapping) when enabled, and advances rr_ptr past the winner.
module btn_rr_arbiter
  import btn_sched_pkg::*;
#(
  parameter int N_BTN = 4,
  localparam int IW   = idx_w(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] req_i,
  input  logic             en_i,
  output logic             grant_vld_o,
  output logic [N_BTN-1:0] grant_o,
  output logic [IW-1:0]    grant_idx_o
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;

  // Search requests starting at rr_ptr, wrapping modulo N_BTN; first hit wins.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    grant_vld_o = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    sum         = 0;
    idx         = '0;
    for (int k = 0; k < N_BTN; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= N_BTN) sum = sum - N_BTN;
      idx = IW'(sum);
      if (!grant_vld_o && en_i && req_i[idx]) begin
        grant_vld_o  = 1'b1;
        grant_idx_o  = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end

  // Next pointer sits just past the winner; unchanged when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld_o) begin
      if (grant_idx_o == IW'(N_BTN - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = grant_idx_o + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Converts synchronised button levels into an ordered stream of press events:
// rising-edge detect -> per-button pending -> round-robin grant -> event FIFO.
module btn_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int IW   = idx_w(N_BTN),
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             evt_ready,
  input  logic             clear_ovf,
  output logic             evt_valid,
  output logic [IW-1:0]    evt_id,
  output logic [PW:0]      fifo_cnt,
  output logic [N_BTN-1:0] pending,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [IW-1:0]    mem_q [DEPTH];

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] merge;
  logic [N_BTN-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             push;
  logic             pop;
  logic             can_push;

  assign rise      = btn & ~btn_q;
  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid & evt_ready;
  // A same-cycle pop frees a slot, so a full FIFO can still accept a push.
  assign can_push  = (cnt_q < (PW+1)'(DEPTH)) | pop;
  // Memory is not reset; mask the head so evt_id reads 0 while empty.
  assign evt_id    = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt  = cnt_q;
  assign pending   = pending_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

  btn_rr_arbiter #(.N_BTN(N_BTN)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (pending_q),
    .en_i        (can_push),
    .grant_vld_o (push),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Pending set/clear and press-merge accounting; clear_ovf wins over increments.
  always_comb begin
    int               nm;
    logic [CNT_W:0]   sum;
    pending_d = (pending_q & ~grant) | rise;
    merge     = rise & pending_q & ~grant;
    nm        = 0;
    for (int i = 0; i < N_BTN; i++) nm = nm + int'(merge[i]);
    sum       = {1'b0, drop_q} + (CNT_W+1)'(nm);
    ovf_d     = ovf_q | (merge != '0);
    drop_d    = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q     <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      btn_q     <= btn;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Event storage; only written on a granted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

endmodule
